// File: rtl/rect_fill.sv
// rect_fill: rectangle-fill engine issuing one RGB565 VRAM write per pixel on the GPU CPU-side bus.
// Optional clipping to the visible screen area is enabled by defining RECT_FILL_CLIP_EN.
module rect_fill #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [8:0]        x0,
    input  logic [7:0]        y0,
    input  logic [8:0]        w,
    input  logic [7:0]        h,
    input  logic [15:0]       color,
    input  logic              grant,
    output logic              busy,
    output logic              done,
    output logic              gpuEnable,
    output logic              gpuWriteEnable,
    output logic [ADDR_W-1:0] gpuAddress,
    output logic [31:0]       gpuDataIn
);
    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

    state_t            state_q, state_d;
    logic [8:0]        x0_q, x0_d, w_q, w_d, w_eff_q, w_eff_d, col_cnt_q, col_cnt_d;
    logic [7:0]        y0_q, y0_d, h_q, h_d, row_cnt_q, row_cnt_d;
    logic [15:0]       color_q, color_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d, addr_q, addr_d, base;
    logic [8:0]        w_eff;
    logic [7:0]        h_eff;

`ifdef RECT_FILL_CLIP_EN
    logic [8:0] w_room;
    logic [7:0] h_room;
    assign w_room = 9'(SCREEN_W) - x0_q;
    assign h_room = 8'(SCREEN_H) - y0_q;
    assign w_eff  = (x0_q >= 9'(SCREEN_W)) ? 9'd0 : ((w_q < w_room) ? w_q : w_room);
    assign h_eff  = (y0_q >= 8'(SCREEN_H)) ? 8'd0 : ((h_q < h_room) ? h_q : h_room);
`else
    assign w_eff = w_q;
    assign h_eff = h_q;
`endif

    // y0*320 + x0 built from two shifts so no multiplier is inferred
    assign base = (ADDR_W'(y0_q) << 8) + (ADDR_W'(y0_q) << 6) + ADDR_W'(x0_q);

    assign busy           = (state_q == SETUP) || (state_q == FILL);
    assign done           = (state_q == DONE);
    assign gpuEnable      = (state_q == FILL) && grant;
    assign gpuWriteEnable = gpuEnable;
    assign gpuAddress     = addr_q;
    assign gpuDataIn      = {color_q, color_q};

    // Next-state logic: latch command, set up row walk, step one pixel per granted cycle
    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        color_d    = color_q;
        w_eff_d    = w_eff_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        col_cnt_d  = col_cnt_q;
        row_cnt_d  = row_cnt_q;
        case (state_q)
            IDLE: if (start) begin
                x0_d    = x0;
                y0_d    = y0;
                w_d     = w;
                h_d     = h;
                color_d = color;
                state_d = SETUP;
            end
            SETUP: begin
                row_base_d = base;
                addr_d     = base;
                w_eff_d    = w_eff;
                col_cnt_d  = w_eff;
                row_cnt_d  = h_eff;
                state_d    = (w_eff == 9'd0 || h_eff == 8'd0) ? DONE : FILL;
            end
            FILL: if (grant) begin
                if (col_cnt_q == 9'd1) begin
                    row_base_d = row_base_q + ADDR_W'(SCREEN_W);
                    addr_d     = row_base_q + ADDR_W'(SCREEN_W);
                    col_cnt_d  = w_eff_q;
                    row_cnt_d  = row_cnt_q - 8'd1;
                    state_d    = (row_cnt_q == 8'd1) ? DONE : FILL;
                end else begin
                    col_cnt_d = col_cnt_q - 9'd1;
                    addr_d    = addr_q + ADDR_W'(1);
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            w_eff_q    <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            col_cnt_q  <= '0;
            row_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            color_q    <= color_d;
            w_eff_q    <= w_eff_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            col_cnt_q  <= col_cnt_d;
            row_cnt_q  <= row_cnt_d;
        end
    end
endmodule

// File: tb/tb_rect_fill.sv
// tb_rect_fill: scoreboard bench for rect_fill; expectations follow RECT_FILL_CLIP_EN when defined.
module tb_rect_fill;
    logic        clk = 1'b0;
    logic        rst_n, start, grant;
    logic [8:0]  x0, w;
    logic [7:0]  y0, h;
    logic [15:0] color;
    logic        busy, done, gpuEnable, gpuWriteEnable;
    logic [16:0] gpuAddress;
    logic [31:0] gpuDataIn;

    typedef struct {
        logic [16:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    rect_fill dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x0(x0), .y0(y0), .w(w), .h(h),
        .color(color), .grant(grant), .busy(busy), .done(done), .gpuEnable(gpuEnable),
        .gpuWriteEnable(gpuWriteEnable), .gpuAddress(gpuAddress), .gpuDataIn(gpuDataIn)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push(input int a, input logic [15:0] c);
        exp_t e;
        e.a = 17'(a);
        e.d = {c, c};
        sb.push_back(e);
    endtask

    // monitor: every bus write must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        chk(gpuEnable === gpuWriteEnable && !(gpuWriteEnable === 1'b1 && grant !== 1'b1),
            "we_vs_grant", {gpuEnable, gpuWriteEnable}, {grant, grant});
        if (gpuWriteEnable === 1'b1) begin
            if (sb.size() == 0) begin
                chk(1'b0, "unexpected_write_addr", gpuAddress, -1);
            end else begin
                e = sb.pop_front();
                chk(gpuAddress === e.a, "write_addr", gpuAddress, e.a);
                chk(gpuDataIn === e.d, "write_data", gpuDataIn, e.d);
            end
        end
    end

    // issue one command; k counts cycles from acceptance (cycle 0) to done
    task automatic run(input string name, input logic [8:0] x, input logic [7:0] y,
                       input logic [8:0] ww, input logic [7:0] hh, input logic [15:0] c,
                       input bit tog, input bit hold, input int exp_done);
        int k;
        bit got;
        @(posedge clk); #1;
        x0 = x; y0 = y; w = ww; h = hh; color = c; start = 1'b1; grant = 1'b1;
        k = 0;
        got = 1'b0;
        while (!got && k < 200) begin
            @(negedge clk);
            chk(busy === (k >= 1 && k < exp_done), {name, "_busy"}, busy, (k >= 1 && k < exp_done));
            if (done === 1'b1) got = 1'b1;
            else begin
                @(posedge clk); #1;
                k++;
                if (hold) begin
                    x0 = 9'd100; y0 = 8'd1; w = 9'd7; h = 8'd2; color = 16'h1234;
                end else start = 1'b0;
                if (tog) grant = (k % 2 == 0);
            end
        end
        chk(got && k == exp_done, {name, "_done_cycle"}, got ? k : -1, exp_done);
        @(posedge clk); #1;
        start = 1'b0;
        grant = 1'b1;
        repeat (4) @(posedge clk);
        chk(sb.size() == 0, {name, "_writes_left"}, sb.size(), 0);
    endtask

    initial begin
        int ndone;
        rst_n = 1'b0; start = 1'b0; grant = 1'b1;
        x0 = '0; y0 = '0; w = '0; h = '0; color = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({busy, done, gpuEnable, gpuWriteEnable} === 4'b0, "reset_ctrl",
            {busy, done, gpuEnable, gpuWriteEnable}, 0);
        chk(gpuAddress === 17'd0 && gpuDataIn === 32'd0, "reset_bus", gpuAddress, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        push(0, 16'hF800); push(1, 16'hF800); push(320, 16'hF800); push(321, 16'hF800);
        run("basic", 9'd0, 8'd0, 9'd2, 8'd2, 16'hF800, 1'b0, 1'b0, 6);

        push(1610, 16'h001F); push(1611, 16'h001F); push(1612, 16'h001F);
        run("mid", 9'd10, 8'd5, 9'd3, 8'd1, 16'h001F, 1'b0, 1'b0, 5);

        push(644, 16'hABCD); push(645, 16'hABCD); push(646, 16'hABCD); push(647, 16'hABCD);
        run("throttle", 9'd4, 8'd2, 9'd4, 8'd1, 16'hABCD, 1'b1, 1'b0, 9);

        run("zero", 9'd3, 8'd3, 9'd0, 8'd7, 16'hFFFF, 1'b0, 1'b0, 2);

`ifdef RECT_FILL_CLIP_EN
        push(76798, 16'h5A5A); push(76799, 16'h5A5A);
        run("clip", 9'd318, 8'd239, 9'd5, 8'd3, 16'h5A5A, 1'b0, 1'b0, 4);
`else
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++) push(76798 + r * 320 + c, 16'h5A5A);
        run("clip", 9'd318, 8'd239, 9'd5, 8'd3, 16'h5A5A, 1'b0, 1'b0, 17);
`endif

        push(20, 16'h0F0F); push(21, 16'h0F0F); push(22, 16'h0F0F);
        run("ignored_start", 9'd20, 8'd0, 9'd3, 8'd1, 16'h0F0F, 1'b0, 1'b1, 5);

        @(posedge clk); #1;
        x0 = 9'd0; y0 = 8'd10; w = 9'd10; h = 8'd1; color = 16'h07E0; start = 1'b1;
        push(3200, 16'h07E0); push(3201, 16'h07E0); push(3202, 16'h07E0);
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({busy, done, gpuEnable, gpuWriteEnable} === 4'b0, "midfill_reset_ctrl",
            {busy, done, gpuEnable, gpuWriteEnable}, 0);
        chk(gpuAddress === 17'd0 && gpuDataIn === 32'd0, "midfill_reset_bus", gpuAddress, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk(ndone == 0, "no_done_after_reset", ndone, 0);
        chk(sb.size() == 0, "reset_writes_left", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=%0t expected=finish", $time);
        $fatal(1, "timeout");
    end
endmodule
